ram_wr_seq_1024x18: RTL and testbench
=====================================

// Module: ram_wr_seq_1024x18
// PURPOSE
// - Upstream write sequencer for the 1024x18 single-port RAM with registered-address read.
// - Accepts a valid/ready stream of 18-bit words and issues one RAM write per word.
// - Writes go to consecutive addresses from a programmed base; the address wraps modulo 1024.
// - Signals completion of a programmed-length burst. The RAM latches its read address only on writes, so last_addr also tells the reader which word appears on dout.
// PARAMETERS
// - DW     18    data width (RAM word)
// - AW     10    address width
// - DEPTH  1024  RAM depth = 2**AW; maximum burst length
// PORTS
// - clk        in   1      single clock, rising edge
// - rst_n      in   1      reset, asynchronous assert, active-low
// - start      in   1      burst start pulse; sampled in IDLE only
// - base_addr  in   AW     first write address, sampled with start
// - len        in   AW+1   words in burst, sampled with start; 0 = empty burst; >DEPTH clamps to DEPTH
// - abort      in   1      terminate burst; overrides everything except reset
// - s_valid    in   1      stream word valid
// - s_data     in   DW     stream word
// - s_ready    out  1      stream ready
// - ram_we     out  1      RAM write enable (registered)
// - ram_addr   out  AW     RAM address (registered)
// - ram_di     out  DW     RAM write data (registered)
// - busy       out  1      burst in progress
// - done       out  1      one-cycle pulse: burst completed normally
// - aborted    out  1      one-cycle pulse: burst terminated by abort
// - last_addr  out  AW     address of the most recent write; 0 after reset
// BEHAVIOUR
// - Reset values: state=IDLE; all outputs 0 (s_ready, ram_we, ram_addr, ram_di, busy, done, aborted, last_addr).
// - FSM states: IDLE, RUN, FIN.
//   - IDLE->RUN: on start with len!=0. Load addr<=base_addr and cnt<=min(len,DEPTH).
//   - IDLE->FIN: on start with len==0. No writes are issued.
//   - RUN->FIN: when the beat that takes cnt to 0 is accepted.
//   - FIN->IDLE: unconditionally, after one cycle.
// - s_ready = (state==RUN), combinational from state. A beat is accepted when s_valid && s_ready.
// - Write timing: a beat accepted in cycle N drives ram_we=1, ram_addr=addr, ram_di=s_data in cycle N+1.
//   - Same edge: addr<=addr+1 (mod 2**AW, 1023->0); cnt<=cnt-1; last_addr<=addr.
//   - ram_we=0 in every cycle with no accepted beat. ram_addr and ram_di hold their last values.
// - Flow control: s_valid gaps stall RUN indefinitely. No timeout.
// - Completion: FIN is entered on the edge after the last accept, so done=1 in the same cycle as the last ram_we.
// - busy=1 in RUN only. busy drops in the cycle done pulses.
// - start is ignored while state!=IDLE.
// - start and abort in the same IDLE cycle: abort wins. Stay in IDLE with no pulses.
// - abort in RUN:
//   - Any beat offered in that cycle is not accepted; s_ready is forced to 0 combinationally.
//   - Next cycle: state=IDLE, aborted=1, no done pulse. The write from a beat accepted the cycle before still completes.
// - Wrap: base_addr=1020 with len=8 writes 1020..1023, then 0..3.
// - rst_n asserted mid-burst: everything returns to reset values immediately. The partial burst is lost.
// CONFIGURATION
// - WR_SEQ_CHECKSUM_EN defined:
//   - Adds output csum[DW-1:0]: mod-2**DW sum of all words written in the current burst.
//   - csum clears on start and updates in the same cycle as each ram_we.
//   - Valid when done pulses; holds until the next start. Reset value 0.
// - WR_SEQ_CHECKSUM_EN undefined: no csum port and no accumulator logic.
// STRUCTURE
// - Shared package ram_wr_seq_pkg:
//   - constants DW, AW, DEPTH
//   - typedef enum logic [1:0] {IDLE, RUN, FIN} wr_seq_state_t
// - Sub-module ram_wr_seq_csum (accumulator with clear/enable), instantiated only under WR_SEQ_CHECKSUM_EN.
// - Otherwise a single module: FSM, address counter, word counter, output registers.
// TESTING
// - Sequencing: base=0, len=4, s_valid held high, data 0x00001..0x00004.
//   - Expect 4 ram_we cycles at addr 0..3 with matching di, done in the 4th write cycle, last_addr=3.
//   - Expect ram_we=0 in every other cycle.
// - Wrap-around: base=1022, len=4 -> writes at addr 1022, 1023, 0, 1; done pulses once.
// - Backpressure: len=3 with s_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, each one cycle after its accept; busy=1 throughout.
// - Empty and clamped bursts:
//   - len=0 -> FIN one cycle after start, done pulses, no ram_we.
//   - len=2000 -> exactly 1024 writes, then done.
// - Abort and start-while-busy:
//   - abort after 2 of 5 accepts -> 2 writes, aborted=1 for one cycle, no done.
//   - start pulsed mid-burst -> ignored.
//   - rst_n low mid-burst -> all outputs 0 immediately.
// - With WR_SEQ_CHECKSUM_EN: words 0x3FFFF and 0x00002 -> csum=0x00001 at done.

Source files
------------

// File: rtl/ram_wr_seq_pkg.sv
// Shared constants and FSM encoding for the 1024x18 RAM write sequencer.
// Optional checksum feature is enabled by defining WR_SEQ_CHECKSUM_EN.
package ram_wr_seq_pkg;

   localparam int DW    = 18;
   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   localparam logic [AW:0] MAX_LEN  = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE_BEAT = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } wr_seq_state_t;

   // Requested lengths above the RAM depth are limited to one full pass.
   function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
      return (l > MAX_LEN) ? MAX_LEN : l;
   endfunction

endpackage

// File: rtl/ram_wr_seq_csum.sv
// Running mod-2**DW sum of written words; clear has priority over accumulate.
// Only instantiated when WR_SEQ_CHECKSUM_EN is defined.
module ram_wr_seq_csum
   import ram_wr_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] csum
);

   logic [DW-1:0] sum_q;
   logic [DW-1:0] sum_d;

   always_comb begin
      sum_d = sum_q;
      if (clr) begin
         sum_d = '0;
      end else if (en) begin
         sum_d = sum_q + din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign csum = sum_q;

endmodule

// File: rtl/ram_wr_seq_1024x18.sv
// Stream-to-RAM write sequencer: one registered RAM write per accepted beat,
// consecutive wrapping addresses, done/aborted pulses. Macro: WR_SEQ_CHECKSUM_EN.
module ram_wr_seq_1024x18
   import ram_wr_seq_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base_addr,
   input  logic [AW:0]   len,
   input  logic          abort,
   input  logic          s_valid,
   input  logic [DW-1:0] s_data,
   output logic          s_ready,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_di,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic [AW-1:0] last_addr
`ifdef WR_SEQ_CHECKSUM_EN
   ,
   output logic [DW-1:0] csum
`endif
);

   // Handshake: a beat transfers on a rising edge where s_valid && s_ready;
   // s_ready is high only in RUN and is pulled low by abort in the same cycle.

   wr_seq_state_t state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ram_we_q, ram_we_d;
   logic [AW-1:0] ram_addr_q, ram_addr_d;
   logic [DW-1:0] ram_di_q, ram_di_d;
   logic [AW-1:0] last_addr_q, last_addr_d;
   logic          aborted_q, aborted_d;

   logic          accept;
   logic          start_go;

   assign s_ready  = (state_q == RUN) && !abort;
   assign accept   = s_valid && s_ready;
   assign start_go = (state_q == IDLE) && start && !abort;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_di_d    = ram_di_q;
      last_addr_d = last_addr_q;
      aborted_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_go) begin
               if (len == '0) begin
                  state_d = FIN;
               end else begin
                  state_d = RUN;
                  addr_d  = base_addr;
                  cnt_d   = clamp_len(len);
               end
            end
         end

         RUN: begin
            if (abort) begin
               state_d   = IDLE;
               aborted_d = 1'b1;
            end else if (accept) begin
               ram_we_d    = 1'b1;
               ram_addr_d  = addr_q;
               ram_di_d    = s_data;
               last_addr_d = addr_q;
               // AW-bit add gives the 1023->0 wrap for free.
               addr_d      = addr_q + 1'b1;
               cnt_d       = cnt_q - ONE_BEAT;
               if (cnt_q == ONE_BEAT) begin
                  state_d = FIN;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         cnt_q       <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_di_q    <= '0;
         last_addr_q <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_di_q    <= ram_di_d;
         last_addr_q <= last_addr_d;
         aborted_q   <= aborted_d;
      end
   end

   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_di    = ram_di_q;
   assign last_addr = last_addr_q;
   assign aborted   = aborted_q;
   assign busy      = (state_q == RUN);
   // FIN follows the last accept, so done lines up with the final ram_we.
   assign done      = (state_q == FIN);

`ifdef WR_SEQ_CHECKSUM_EN
   ram_wr_seq_csum u_csum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_go),
      .en    (accept),
      .din   (s_data),
      .csum  (csum)
   );
`endif

endmodule

// File: tb/tb_ram_wr_seq_1024x18.sv
// Bench for ram_wr_seq_1024x18: driver tasks push expected writes into a queue,
// a negedge monitor pops and compares every ram_we cycle.
module tb_ram_wr_seq_1024x18;
  import ram_wr_seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          abort;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] last_addr;
`ifdef WR_SEQ_CHECKSUM_EN
  logic [DW-1:0] csum;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_wr_seq_1024x18 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .abort     (abort),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .last_addr (last_addr)
`ifdef WR_SEQ_CHECKSUM_EN
    ,
    .csum      (csum)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [DW-1:0]    exp_csum;
  logic [DW-1:0]    dtab[$];
  int wr_cnt, done_cnt, abort_cnt, done_with_we, busy_low;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [AW+DW-1:0] mon_e;
  int               mon_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got write addr=%0d di=0x%0h, expected none", ram_addr, ram_di);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          check("wr_addr_data", 32'({ram_addr, ram_di}), 32'(mon_e));
          check("wr_latency", cyc, mon_c + 1);
        end
      end
      if (done) begin
        done_cnt++;
        done_with_we = int'(ram_we);
        check("done_not_busy", 32'(busy), 0);
`ifdef WR_SEQ_CHECKSUM_EN
        check("csum_at_done", 32'(csum), 32'(exp_csum));
`endif
      end
      if (aborted) abort_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    wr_cnt = 0; done_cnt = 0; abort_cnt = 0; done_with_we = 0; busy_low = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},   32'(s_ready),   0);
    check({tag, "_ram_we"},    32'(ram_we),    0);
    check({tag, "_ram_addr"},  32'(ram_addr),  0);
    check({tag, "_ram_di"},    32'(ram_di),    0);
    check({tag, "_busy"},      32'(busy),      0);
    check({tag, "_done"},      32'(done),      0);
    check({tag, "_aborted"},   32'(aborted),   0);
    check({tag, "_last_addr"}, 32'(last_addr), 0);
`ifdef WR_SEQ_CHECKSUM_EN
    check({tag, "_csum"},      32'(csum),      0);
`endif
  endtask

  // vmode: 0 always valid, 1 pattern 1,0,0,1,0,1, 2 random.
  // dmode: 0 random, 1 index+1, 2 from dtab.
  task automatic run_burst(input int base, input int ln, input int vmode, input int dmode,
                           input int abort_after, input bit mid_start, output int n_acc);
    int n_exp, acc, k;
    bit ab;
    logic [5:0] pat;
    pat   = 6'b101001;
    n_exp = (ln == 0) ? 0 : ((ln > DEPTH) ? DEPTH : ln);
    clear_counts();
    exp_csum = '0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); len = (AW+1)'(ln);
    @(posedge clk); #1;
    start = 1'b0;
    acc = 0; k = 0;
    while (acc < n_exp) begin
      if (k > 5000) begin
        checks++; errors++;
        $display("FAIL burst_timeout: got %0d accepts, expected %0d", acc, n_exp);
        break;
      end
      ab      = (abort_after >= 0) && (acc == abort_after);
      abort   = ab;
      s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[k % 6] : 1'($urandom_range(0, 1));
      s_data  = (dmode == 0) ? DW'($urandom) : (dmode == 1) ? DW'(acc + 1) : dtab[acc];
      if (mid_start && k == 2) begin
        start = 1'b1; base_addr = AW'($urandom); len = (AW+1)'($urandom_range(0, 2047));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      if (ab) begin
        check("abort_blocks_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        break;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back({AW'(base + acc), s_data});
        exp_cyc_q.push_back(cyc);
        exp_csum = exp_csum + s_data;
        acc++;
      end
      @(posedge clk); #1;
      k++;
    end
    s_valid = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_acc = acc;
  endtask

  task automatic end_checks(input string tag, input int base, input int exp_wr,
                            input int exp_done, input int exp_ab);
    check({tag, "_wr_count"},    wr_cnt,        exp_wr);
    check({tag, "_done_count"},  done_cnt,      exp_done);
    check({tag, "_abort_count"}, abort_cnt,     exp_ab);
    check({tag, "_queue_empty"}, exp_q.size(),  0);
    check({tag, "_busy_in_run"}, busy_low,      0);
    check({tag, "_idle_after"},  32'({busy, s_ready}), 0);
    if (exp_wr > 0) check({tag, "_last_addr"}, 32'(last_addr), (base + exp_wr - 1) % DEPTH);
    if (exp_done > 0) check({tag, "_done_with_we"}, done_with_we, (exp_wr > 0) ? 1 : 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n, b, l;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0;
    abort = 1'b0; s_valid = 1'b0; s_data = '0;
    clear_counts();
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run_burst(0, 4, 0, 1, -1, 1'b0, n);
    end_checks("seq", 0, 4, 1, 0);

    run_burst(1022, 4, 0, 0, -1, 1'b0, n);
    end_checks("wrap", 1022, 4, 1, 0);

    run_burst(100, 3, 1, 0, -1, 1'b0, n);
    end_checks("bp", 100, 3, 1, 0);

    run_burst(55, 0, 0, 0, -1, 1'b0, n);
    end_checks("empty", 55, 0, 1, 0);

    run_burst(7, 2000, 0, 0, -1, 1'b0, n);
    end_checks("clamp", 7, DEPTH, 1, 0);

    run_burst(300, 5, 0, 0, 2, 1'b0, n);
    end_checks("abort", 300, 2, 0, 1);

    run_burst(900, 6, 0, 0, -1, 1'b1, n);
    end_checks("midstart", 900, 6, 1, 0);

    // start and abort together in IDLE: nothing happens.
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; base_addr = AW'(10); len = (AW+1)'(4);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    end_checks("start_abort", 10, 0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 40);
      run_burst(b, l, 2, 0, -1, 1'b0, n);
      end_checks("rand", b, l, 1, 0);
    end

`ifdef WR_SEQ_CHECKSUM_EN
    dtab.delete();
    dtab.push_back(18'h3FFFF);
    dtab.push_back(18'h00002);
    run_burst(40, 2, 0, 2, -1, 1'b0, n);
    end_checks("csum", 40, 2, 1, 0);
    check("csum_wrap_value", 32'(csum), 32'h1);
`endif

    // Reset in the middle of a burst.
    clear_counts();
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(5); len = (AW+1)'(10);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = DW'($urandom);
      @(negedge clk);
      if (s_valid && s_ready) begin
        exp_q.push_back({AW'(5 + i), s_data});
        exp_cyc_q.push_back(cyc);
      end
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_cyc_q.delete();
    s_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;

    run_burst(12, 5, 2, 0, -1, 1'b0, n);
    end_checks("after_reset", 12, 5, 1, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
